// File: rtl/fetch_sequencer_if.sv
// Instruction-memory and decode handshake bundle between the fetch sequencer and its neighbours.
// master = sequencer side, slave = memory/decode side.
`timescale 1ns/1ps
interface fetch_sequencer_if #(
    parameter int bit_size  = 18,
    parameter int data_size = 32
);
    logic                 im_req;
    logic [bit_size-1:0]  im_addr;
    logic                 im_ack;
    logic [data_size-1:0] im_rdata;
    logic [data_size-1:0] instr;
    logic                 instr_valid;
    logic                 instr_ready;

    modport master (
        output im_req, im_addr, instr, instr_valid,
        input  im_ack, im_rdata, instr_ready
    );

    modport slave (
        input  im_req, im_addr, instr, instr_valid,
        output im_ack, im_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-PC / instruction-fetch sequencer closing the loop around an enable-less PC register.
// Latency: >=1 REQ cycle per fetch; backpressure: instr held and pc_next=pc_cur until instr_ready & ~stall.
`timescale 1ns/1ps
module fetch_sequencer #(
    parameter int bit_size  = 18,
    parameter int data_size = 32
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   bus,
    input  logic [bit_size-1:0] pc_cur,
    output logic [bit_size-1:0] pc_next,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [15:0]         br_offset,
    input  logic                jump,
    input  logic [bit_size-3:0] jump_index,
    input  logic                jr,
    input  logic [bit_size-1:0] jr_addr,
    output logic [31:0]         fetch_count
);

    typedef enum logic [1:0] {IDLE, REQ, VALID} state_t;

    state_t               state_q;
    logic                 im_req_q;
    logic [bit_size-1:0]  im_addr_q;
    logic [data_size-1:0] instr_q;
    logic                 instr_valid_q;
    logic [31:0]          fetch_count_q;

    logic                 advance;
    logic [bit_size-1:0]  seq_pc;
    logic [bit_size-1:0]  br_disp;
    logic [bit_size-1:0]  target_d;
    logic [bit_size-1:0]  pc_next_d;
    logic                 unused_jr_lo;

    assign advance      = bus.instr_ready & ~stall;
    // Misaligned register targets are silently re-aligned, so the low bits never matter.
    assign unused_jr_lo = ^jr_addr[1:0];

    always_comb begin
        seq_pc   = pc_cur + bit_size'(4);
        br_disp  = bit_size'({{bit_size{br_offset[15]}}, br_offset, 2'b00});
        target_d = seq_pc;
        if (jr) begin
            target_d = {jr_addr[bit_size-1:2], 2'b00};
        end else if (jump) begin
            target_d = {jump_index, 2'b00};
        end else if (br_taken) begin
            target_d = seq_pc + br_disp;
        end
        pc_next_d = pc_cur;
        if (state_q == VALID && advance) begin
            pc_next_d = target_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            im_req_q      <= 1'b0;
            im_addr_q     <= '0;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q   <= REQ;
                    im_req_q  <= 1'b1;
                    im_addr_q <= pc_cur;
                end
                REQ: begin
                    if (bus.im_ack) begin
                        instr_q       <= bus.im_rdata;
                        im_req_q      <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= VALID;
                    end
                end
                VALID: begin
                    // The PC register loads pc_next on this same edge, so target is the next fetch address.
                    if (advance) begin
                        instr_valid_q <= 1'b0;
                        im_req_q      <= 1'b1;
                        im_addr_q     <= pc_next_d;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        state_q       <= REQ;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pc_next         = pc_next_d;
    assign bus.im_req      = im_req_q;
    assign bus.im_addr     = im_addr_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign fetch_count     = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: models the PC register, instruction memory and decode; scoreboards each retired instruction.
`timescale 1ns/1ps
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic [17:0] pc_cur;
    logic [17:0] pc_next;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_offset;
    logic        jump;
    logic [15:0] jump_index;
    logic        jr;
    logic [17:0] jr_addr;
    logic [31:0] fetch_count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] instr;
        logic [17:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    fetch_sequencer_if #(.bit_size(18), .data_size(32)) bus ();

    fetch_sequencer #(.bit_size(18), .data_size(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .pc_cur      (pc_cur),
        .pc_next     (pc_next),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_offset   (br_offset),
        .jump        (jump),
        .jump_index  (jump_index),
        .jr          (jr),
        .jr_addr     (jr_addr),
        .fetch_count (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PC register without enable, as the sequencer expects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pc_cur <= '0;
        else      pc_cur <= pc_next;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic serve(input int delay, input logic [31:0] data, input logic [17:0] exp_addr);
        int n;
        n = 0;
        while (!bus.im_req && n < 20) begin
            tick();
            n++;
        end
        chk("req_seen", {31'd0, bus.im_req}, 32'd1);
        for (int i = 0; i <= delay; i++) begin
            chk("req_hold", {31'd0, bus.im_req}, 32'd1);
            chk("req_addr", {14'd0, bus.im_addr}, {14'd0, exp_addr});
            chk("wait_pc_hold", {14'd0, pc_next}, {14'd0, pc_cur});
            chk("wait_no_valid", {31'd0, bus.instr_valid}, 32'd0);
            if (i == delay) begin
                bus.im_ack   = 1'b1;
                bus.im_rdata = data;
            end
            tick();
        end
        bus.im_ack   = 1'b0;
        bus.im_rdata = $urandom;
        chk("fetch_valid", {31'd0, bus.instr_valid}, 32'd1);
        chk("fetch_instr", bus.instr, data);
        chk("req_drop", {31'd0, bus.im_req}, 32'd0);
    endtask

    task automatic retire(input logic [31:0] ins, input logic [17:0] exp_pc, input logic [31:0] exp_cnt);
        exp_t e;
        e.instr = ins;
        e.pc    = exp_pc;
        e.cnt   = exp_cnt;
        sb.push_back(e);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
    endtask

    // Monitor: every accepted instruction must match the next scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst && bus.instr_valid && bus.instr_ready && !stall) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 32'd1);
                end else begin
                    e = sb.pop_front();
                    chk("mon_instr", bus.instr, e.instr);
                    chk("mon_pc_next", {14'd0, pc_next}, {14'd0, e.pc});
                    chk("mon_count", fetch_count, e.cnt);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        stall = 1'b0; br_taken = 1'b0; br_offset = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_addr = '0;
        bus.im_ack = 1'b0; bus.im_rdata = '0; bus.instr_ready = 1'b0;

        tick(); tick();
        chk("rst_im_req", {31'd0, bus.im_req}, 32'd0);
        chk("rst_im_addr", {14'd0, bus.im_addr}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_pc_next", {14'd0, pc_next}, {14'd0, pc_cur});

        rst = 1'b1;
        tick();
        chk("idle_to_req", {31'd0, bus.im_req}, 32'd1);
        serve(0, 32'h2008_0005, 18'h00000);
        retire(32'h2008_0005, 18'h00004, 32'd0);
        chk("count_after_1", fetch_count, 32'd1);
        chk("pc_after_1", {14'd0, pc_cur}, 32'h4);

        // Delayed ack, then a misaligned register jump.
        serve(3, 32'h8C01_0000, 18'h00004);
        jr = 1'b1; jr_addr = 18'h00013;
        retire(32'h8C01_0000, 18'h00010, 32'd1);
        jr = 1'b0;

        // Target priority, evaluated combinationally within one cycle.
        serve(1, 32'h1000_0003, 18'h00010);
        stall = 1'b0; bus.instr_ready = 1'b1;
        br_taken = 1'b1; br_offset = 16'hFFFC;
        #1 chk("tgt_branch", {14'd0, pc_next}, 32'h00004);
        jump = 1'b1; jump_index = 16'h0040;
        #1 chk("tgt_jump", {14'd0, pc_next}, 32'h00100);
        jr = 1'b1; jr_addr = 18'h00203;
        #1 chk("tgt_jr", {14'd0, pc_next}, 32'h00200);
        jr_addr = 18'h3FFFE;
        retire(32'h1000_0003, 18'h3FFFC, 32'd2);
        br_taken = 1'b0; jump = 1'b0; jr = 1'b0;

        // Stall hold at the top of the address space, with stray acks and controls ignored.
        serve(0, 32'h0800_0040, 18'h3FFFC);
        for (int i = 0; i < 5; i++) begin
            stall = 1'b1; bus.instr_ready = 1'b1;
            jump = 1'b1; jump_index = 16'h0055;
            bus.im_ack = 1'b1; bus.im_rdata = 32'hBADB_AD00 + i;
            tick();
            chk("stall_instr", bus.instr, 32'h0800_0040);
            chk("stall_valid", {31'd0, bus.instr_valid}, 32'd1);
            chk("stall_pc_hold", {14'd0, pc_next}, {14'd0, pc_cur});
            chk("stall_pc_cur", {14'd0, pc_cur}, 32'h3FFFC);
            chk("stall_count", fetch_count, 32'd3);
        end
        bus.im_ack = 1'b0; jump = 1'b0; stall = 1'b0; bus.instr_ready = 1'b0;
        retire(32'h0800_0040, 18'h00000, 32'd3);
        chk("wrap_count", fetch_count, 32'd4);
        chk("wrap_pc_cur", {14'd0, pc_cur}, 32'h0);
        chk("single_adv", {31'd0, bus.instr_valid}, 32'd0);
        chk("wrap_req_addr", {14'd0, bus.im_addr}, 32'h0);

        // Reset during REQ, then a stray ack while IDLE.
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, bus.im_req}, 32'd0);
        chk("mid_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("mid_rst_count", fetch_count, 32'd0);
        chk("mid_rst_instr", bus.instr, 32'd0);
        tick();
        rst = 1'b1;
        bus.im_ack = 1'b1; bus.im_rdata = 32'hDEAD_BEEF;
        tick();
        bus.im_ack = 1'b0;
        chk("stray_ack_instr", bus.instr, 32'd0);
        chk("stray_ack_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("restart_addr", {14'd0, bus.im_addr}, 32'h0);
        serve(0, 32'h1234_5678, 18'h00000);
        retire(32'h1234_5678, 18'h00004, 32'd0);

        tick();
        chk("sb_drain", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
